// File: rtl/arbitro_rr_param.sv
// Round-robin arbiter/router: pops one word per cycle from an eligible input FIFO and pushes it to
// the output FIFO named by its destination field. Define ARB_DEST_STALL_EN for per-destination stall.
module arbitro_rr_param #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned WORD_SIZE    = 10,
  parameter int unsigned DEST_SIZE    = $clog2(NUM_CHANNELS)
) (
  input  logic                              clk,
  input  logic                              reset_L,
  input  logic                              active,
  input  logic [NUM_CHANNELS-1:0]           fifo_in_empty,
  input  logic [NUM_CHANNELS*WORD_SIZE-1:0] fifo_in_data,
  input  logic [NUM_CHANNELS-1:0]           fifo_out_almost_full,
  output logic [NUM_CHANNELS-1:0]           pop_in,
  output logic [NUM_CHANNELS-1:0]           push_out,
  output logic [WORD_SIZE-1:0]              data_out,
  output logic [DEST_SIZE-1:0]              grant_idx,
  output logic                              stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DEST_SIZE-1:0]    rr_ptr;
  logic [WORD_SIZE-1:0]    head      [NUM_CHANNELS];
  logic [DEST_SIZE-1:0]    head_dest [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] eligible;
  logic                    any_ne;
  logic                    any_elig;
  logic                    grant_vld;
  logic [DEST_SIZE-1:0]    grant;
  logic                    pop_vld;

  // Unpack show-ahead head words and their destination fields
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      head[i]      = fifo_in_data[i*WORD_SIZE +: WORD_SIZE];
      head_dest[i] = head[i][WORD_SIZE-1 -: DEST_SIZE];
    end
  end

`ifdef ARB_DEST_STALL_EN
  // An input is blocked only by the almost-full flag of its own destination
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = !fifo_in_empty[i] && !fifo_out_almost_full[head_dest[i]];
    end
  end
`else
  // Any almost-full output blocks every input
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i] = !fifo_in_empty[i] && !(|fifo_out_almost_full);
    end
  end
`endif

  assign any_ne   = |(~fifo_in_empty);
  assign any_elig = |eligible;

  // First eligible input searching from rr_ptr upwards, wrapping modulo NUM_CHANNELS
  always_comb begin
    logic [DEST_SIZE-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant     = rr_ptr;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = rr_ptr + DEST_SIZE'(k);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Dropping active suppresses the pop in the same cycle
  assign pop_vld = (state == RUN) && active && grant_vld;
  assign pop_in  = (reset_L && pop_vld) ? (NUM_CHANNELS'(1) << grant) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (active && any_ne) state_nxt = RUN;
      end
      RUN: begin
        if (!active || !any_ne) state_nxt = IDLE;
        else if (!any_elig)     state_nxt = HOLD;
      end
      HOLD: begin
        if (!active || !any_ne) state_nxt = IDLE;
        else if (any_elig)      state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer and registered push path; a popped word is pushed exactly one cycle later
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      push_out  <= '0;
      data_out  <= '0;
      grant_idx <= '0;
      stall     <= 1'b0;
    end else begin
      state    <= state_nxt;
      stall    <= (state_nxt == HOLD);
      push_out <= '0;
      if (pop_vld) begin
        push_out  <= NUM_CHANNELS'(1) << head_dest[grant];
        data_out  <= head[grant];
        grant_idx <= grant;
        rr_ptr    <= grant + DEST_SIZE'(1);
      end
    end
  end

endmodule

// File: doc/arbitro_rr_param.md
# arbitro_rr_param

Parametrised round-robin arbiter and router for the transaction layer. It sits between NUM_CHANNELS input FIFOs and NUM_CHANNELS output FIFOs. It pops one word per cycle from the next eligible input FIFO and pushes that word to the output FIFO selected by the word's destination field. Back-pressure comes from the output FIFOs' almost-full flags. The top-level FSM gates the block through `active`.

## Interface
Parameters:
- NUM_CHANNELS, 4, input/output FIFO pairs; power of 2, ≥2
- WORD_SIZE, 10, FIFO word width
- DEST_SIZE, $clog2(NUM_CHANNELS), destination field = word[WORD_SIZE-1 -: DEST_SIZE]

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- active  in  1  arbitration enable from the transaction FSM (ACTIVE state)
- fifo_in_empty  in  NUM_CHANNELS  empty flag per input FIFO
- fifo_in_data  in  NUM_CHANNELS*WORD_SIZE  show-ahead head word per input; channel i at [i*WORD_SIZE +: WORD_SIZE]
- fifo_out_almost_full  in  NUM_CHANNELS  almost-full flag per output FIFO
- pop_in  out  NUM_CHANNELS  one-hot-or-zero pop to input FIFOs (combinational)
- push_out  out  NUM_CHANNELS  one-hot-or-zero push to output FIFOs (registered)
- data_out  out  WORD_SIZE  word accompanying push_out (registered)
- grant_idx  out  DEST_SIZE  index of the last granted input (registered)
- stall  out  1  high while in HOLD

## Operation
- FSM states: IDLE, RUN, HOLD; reset state IDLE.
- IDLE → RUN: `active` and at least one input is non-empty.
- RUN → HOLD: `active`, at least one input is non-empty, and no input is eligible.
- HOLD → RUN: an input becomes eligible.
- Any state → IDLE: `!active`, or all inputs are empty.
- Eligibility, default: input i is eligible if !fifo_in_empty[i] and no fifo_out_almost_full bit is set (global stall).
- Eligibility, with the macro: see Configuration.
- Pops are issued only in RUN. Grant = first eligible i searching rr_ptr, rr_ptr+1, … mod NUM_CHANNELS. pop_in[grant]=1 for that cycle.
- On a grant, rr_ptr ← (grant+1) mod NUM_CHANNELS and grant_idx ← grant. Without a grant, rr_ptr and grant_idx hold.
- Popped word is registered into data_out. push_out[dest] is set for exactly the following cycle; otherwise push_out=0.
- data_out holds its last value when push_out=0.
- Simultaneous `!active` and a pending pop: no pop in that cycle. A word popped in the previous cycle is still pushed; it is never dropped.
- Almost-full threshold must leave ≥1 slot of margin for the single in-flight word.
- Reset asserted mid-operation clears everything immediately, including any in-flight word; that word is lost.

## Timing
- Reset values: pop_in=0, push_out=0, data_out=0, grant_idx=0, stall=0, rr_ptr=0, state=IDLE. pop_in is forced 0 while reset_L=0.
- IDLE→RUN costs 1 cycle: first pop occurs in the cycle after `active` and non-empty are sampled.
- Pop → push latency: exactly 1 cycle.
- Sustained throughput: 1 word/cycle.
- stall rises the cycle after the RUN→HOLD edge.
- A cleared almost_full restores pops 1 cycle after HOLD→RUN.

## Configuration
- ARB_DEST_STALL_EN undefined: global stall. Any set fifo_out_almost_full bit blocks all pops.
- ARB_DEST_STALL_EN defined: per-destination stall.
  - Input i is eligible if non-empty and fifo_out_almost_full[dest(head_i)]=0.
  - Blocked inputs are skipped by the round-robin search and do not advance rr_ptr.
  - HOLD only when every non-empty input is blocked.

## Test plan
- Reset: drive traffic, pull reset_L low mid-stream → all outputs 0 within the same cycle, state IDLE, no push after release until new data.
- Single word: input0 head 10'h0A6, active=1 → pop_in=4'b0001 one cycle later; next cycle push_out=4'b0001, data_out=10'h0A6, grant_idx=0.
- Round robin: all 4 inputs non-empty with heads 10'h0A6, 10'h145, 10'h278, 10'h389 repeated → grants 0,1,2,3,0…; push_out 0001,0010,0100,1000 in order.
- Global stall (macro off): almost_full=4'b0010, all inputs non-empty → no pops, stall=1. Clear it → pops resume from rr_ptr after 1 cycle.
- Per-destination stall (macro on): almost_full=4'b0010, input0 head 10'h1A6, input1 head 10'h278 → input0 skipped, input1 granted, push_out=4'b0100, stall=0.
- Deactivate: drop active the cycle after a pop → that word is still pushed; no further pops; state IDLE.
